// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the 16-channel PWM peripheral.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

    // Channel count and duty width shared by every PWM block.
    localparam int CH_N                = 16;
    localparam int DUTY_W              = 8;

    // System clocks per PWM count step when the top is not overridden.
    localparam int PWM_CLK_DIV_DEFAULT = 13;

    // Duty code that forces the level permanently high.
    localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

    // Terminal value of the PWM counter; the period wraps after this step.
    localparam logic [DUTY_W-1:0] CNT_MAX   = 8'hFF;

    // Prescaler width; wide enough for the largest legal divider (65535).
    localparam int PRESC_W             = 16;

    // Comparator: full-scale duty is a constant 1, zero is a constant 0,
    // everything in between is high while the counter is below the duty.
    function automatic logic pwm_level_f(
        input logic [DUTY_W-1:0] cnt,
        input logic [DUTY_W-1:0] duty
    );
        logic level;
        if (duty == DUTY_FULL) begin
            level = 1'b1;
        end else begin
            level = (cnt < duty);
        end
        return level;
    endfunction

    // Per-channel output select: disabled -> 0, static -> 1, PWM -> level.
    function automatic logic [CH_N-1:0] out_sel_f(
        input logic [CH_N-1:0] en_out,
        input logic [CH_N-1:0] en_pwm,
        input logic            level
    );
        logic [CH_N-1:0] sel;
        sel = (en_out & ~en_pwm) | (en_out & en_pwm & {CH_N{level}});
        return sel;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter, wrap strobe and period_start.
// Latency: wrap is combinational in the last clk of a period; period_start follows it by one clk.
// Backpressure: none; free-running from reset release.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DUTY_W-1:0] pwm_cnt,
    output logic              wrap,
    output logic              period_start
);

    // Last prescaler value; with CLK_DIV==1 this is 0 and tick is always high.
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;

    // One count step every CLK_DIV clks, in the clk where the prescaler is at its last value.
    assign tick = (presc == PRESC_LAST);

    // The counter is about to roll 255->0 at the end of this clk.
    assign wrap = tick && (pwm_cnt == CNT_MAX);

    // Prescaler: 0..CLK_DIV-1, back to 0 on tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Period counter: advances once per tick and rolls over naturally at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // period_start lands on the first clk of every period after the first,
    // because it is only ever set by a real wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

    // The prescaler never leaves its legal range.
    assert property (@(posedge clk) disable iff (!rst_n) presc <= PRESC_LAST)
        else $error("pwm_timebase: prescaler out of range");

    // period_start is a single-clk pulse (periods are at least 256 clks long).
    assert property (@(posedge clk) disable iff (!rst_n) period_start |=> !period_start)
        else $error("pwm_timebase: period_start longer than one clk");

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM with one shared duty; optional duty shadow under PWM_DUTY_SHADOW_EN.
// Latency: enable/duty/counter changes reach out one clk later (duty at next period with the shadow).
// Backpressure: none; outputs are registered and always valid.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_N-1:0]   en_out,
    input  logic [CH_N-1:0]   en_pwm,
    input  logic [DUTY_W-1:0] pwm_duty,
    output logic [CH_N-1:0]   out,
    output logic              period_start
);

    logic [DUTY_W-1:0] pwm_cnt;
    logic              wrap;
    logic [DUTY_W-1:0] duty_eff;
    logic              pwm_level;
    logic [CH_N-1:0]   out_nxt;

    pwm_timebase #(
        .CLK_DIV      (CLK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_cnt      (pwm_cnt),
        .wrap         (wrap),
        .period_start (period_start)
    );

`ifdef PWM_DUTY_SHADOW_EN
    logic [DUTY_W-1:0] duty_shadow;

    // Duty is captured only at the period boundary so a mid-period write
    // never produces a truncated or stretched pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_shadow <= '0;
        end else if (wrap) begin
            duty_shadow <= pwm_duty;
        end
    end

    assign duty_eff = duty_shadow;
`else
    // Without the shadow the register-block value is compared directly.
    assign duty_eff = pwm_duty;
`endif

    // One comparator shared by every channel keeps all PWM edges phase-aligned.
    always_comb begin
        pwm_level = pwm_level_f(pwm_cnt, duty_eff);
        out_nxt   = out_sel_f(en_out, en_pwm, pwm_level);
    end

    // Pad outputs are registered; reset clears them at once, dropping any pulse in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_nxt;
        end
    end

    // Every wrap is followed by a period_start pulse in the next clk.
    assert property (@(posedge clk) disable iff (!rst_n) wrap |=> period_start)
        else $error("pwm_peripheral: period_start missing after wrap");

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at CLK_DIV=13 (3328-clk period).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;   // 13 * 256

    logic        clk;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  pwm_duty;
    logic [15:0] out;
    logic        period_start;

    int tests_run;
    int tests_failed;

    pwm_peripheral #(
        .CLK_DIV      (13)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .pwm_duty     (pwm_duty),
        .out          (out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance falling edges until period_start is seen; cyc is the distance.
    task automatic wait_ps(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!period_start && cyc < 5000);
        check(tag, {31'd0, period_start}, 32'd1);
    endtask

    // Sample n falling edges. hi counts clks with every pwm_mask bit high,
    // lo clks with every pwm_mask bit low; bad counts static-bit errors and
    // PWM bits that disagree with each other.
    task automatic measure(input int n,
                           input logic [15:0] stat_mask, input logic [15:0] stat_val,
                           input logic [15:0] pwm_mask,
                           output int hi, output int lo, output int bad,
                           output int ps_n, output int ps_last);
        hi = 0; lo = 0; bad = 0; ps_n = 0; ps_last = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if ((out & stat_mask) != stat_val) bad++;
            if ((out & pwm_mask) == pwm_mask) hi++;
            else if ((out & pwm_mask) == 16'h0000) lo++;
            else bad++;
            if (period_start) begin
                ps_n++;
                ps_last = i;
            end
        end
    endtask

    initial begin
        int cyc, hi, lo, bad, ps_n, ps_last, bad_rst;
        tests_run    = 0;
        tests_failed = 0;

        // Reset held with every input at 1.
        rst_n    = 1'b0;
        en_out   = 16'hFFFF;
        en_pwm   = 16'hFFFF;
        pwm_duty = 8'hFF;
        bad_rst  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_out", {16'd0, out}, 32'h0);
            check("rst_ps", {31'd0, period_start}, 32'd0);
        end

        // Release: the first period has no leading pulse; the first one is 3328 clks in.
        en_out   = 16'h0000;
        en_pwm   = 16'h0000;
        pwm_duty = 8'd0;
        rst_n    = 1'b1;
        wait_ps("first_ps_seen", cyc);
        check("first_ps_dist", cyc, PERIOD);

        // Static outputs appear one clk later and hold across two periods.
        en_out = 16'h00FF;
        en_pwm = 16'h0000;
        @(negedge clk);
        check("static_next_clk", {16'd0, out}, 32'h00FF);
        measure(2 * PERIOD, 16'hFFFF, 16'h00FF, 16'h0000, hi, lo, bad, ps_n, ps_last);
        check("static_hold", bad, 0);
        check("static_ps_count", ps_n, 2);

        // 50% on channel 0.
        en_out   = 16'h0001;
        en_pwm   = 16'h0001;
        pwm_duty = 8'd128;
        wait_ps("p50_sync", cyc);
        measure(PERIOD, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("p50_high", hi, 1664);
        check("p50_low", lo, 1664);
        check("p50_ps_spacing", ps_last, PERIOD);
        check("p50_ps_count", ps_n, 1);

        // Duty 0: constant low for three periods.
        pwm_duty = 8'd0;
        wait_ps("d0_sync", cyc);
        measure(3 * PERIOD, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("d0_high", hi, 0);
        check("d0_ps_count", ps_n, 3);

        // Duty 255: constant high for three periods.
        pwm_duty = 8'd255;
        wait_ps("d255_sync", cyc);
        measure(3 * PERIOD, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("d255_high", hi, 3 * PERIOD);

        // Duty 64 -> 192 written at pwm_cnt=100 (clk 1300 of the period).
        pwm_duty = 8'd64;
        wait_ps("shadow_sync", cyc);
        measure(1300, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("dchg_first_part", hi, 64 * 13);
        pwm_duty = 8'd192;
`ifdef PWM_DUTY_SHADOW_EN
        measure(PERIOD - 1300, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("shadow_rest_high", hi, 0);
        check("shadow_rest_ps", ps_last, PERIOD - 1300);
`else
        @(negedge clk);
        check("direct_rise", {31'd0, out[0]}, 32'd1);
        measure(PERIOD - 1301, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("direct_rest_high", hi, 2496 - 1301);
        check("direct_rest_ps", ps_last, PERIOD - 1301);
`endif
        measure(PERIOD, 16'hFFFE, 16'h0000, 16'h0001, hi, lo, bad, ps_n, ps_last);
        check("dchg_next_period", hi, 192 * 13);

        // Mixed: even bits static high, odd bits pulse together at duty 32.
        en_out   = 16'hFFFF;
        en_pwm   = 16'hAAAA;
        pwm_duty = 8'd32;
        wait_ps("mixed_sync", cyc);
        measure(PERIOD, 16'h5555, 16'h5555, 16'hAAAA, hi, lo, bad, ps_n, ps_last);
        check("mixed_bad", bad, 0);
        check("mixed_high", hi, 32 * 13);
        check("mixed_ps_spacing", ps_last, PERIOD);

        // Reset in the middle of a pulse clears out at once, then the
        // timebase restarts from the beginning of a period.
        pwm_duty = 8'd255;
        wait_ps("midrst_sync", cyc);
        repeat (100) @(negedge clk);
        check("midrst_before", {16'd0, out}, 32'hFFFF);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out", {16'd0, out}, 32'h0);
        check("midrst_ps", {31'd0, period_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps("midrst_ps_seen", cyc);
        check("midrst_ps_dist", cyc, PERIOD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
